rv32i_multicycle_ctrl: RTL

Multicycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath select lines, including the 4-bit `alusel` code consumed by the ALU. It sits between the instruction register, register file, memory handshake and ALU, and issues every datapath enable.

---
 rtl/rv32i_pkg.sv | 51 +++++
 rtl/rv32i_alu_decode.sv | 45 ++++
 rtl/rv32i_multicycle_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multicycle control path: ALU codes, opcodes,
// immediate formats, writeback sources and controller states.
package rv32i_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SRA    = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1110;
  localparam logic [3:0] ALU_PASS_A = 4'b1111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

endpackage

// File: rtl/rv32i_alu_decode.sv
// Combinational ALU-operation decode from opcode/funct3/funct7[5], flagging
// funct3 and funct7[5] combinations that fall outside the RV32I base set.
module rv32i_alu_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alusel,
  output logic       illegal
);

  always_comb begin
    alusel  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        case (funct3)
          3'b000: alusel = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin
            alusel  = ALU_SLL;
            illegal = funct7_b5;
          end
          3'b010: alusel = ALU_SLT;
          3'b011: alusel = ALU_SLTU;
          3'b100: alusel = ALU_XOR;
          3'b101: alusel = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110: alusel = ALU_OR;
          3'b111: alusel = ALU_AND;
        endcase
        // Register-register ops only accept funct7[5] on ADD/SUB and SRL/SRA
        if (opcode == OPC_OP && funct7_b5 && funct3 != 3'b000 && funct3 != 3'b101)
          illegal = 1'b1;
      end
      OPC_LUI:             alusel  = ALU_PASS_B;
      OPC_AUIPC, OPC_JAL:  alusel  = ALU_ADD;
      OPC_JALR:            illegal = (funct3 != 3'b000);
      OPC_BRANCH:          illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD:            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OPC_STORE:           illegal = funct3[2] || (funct3 == 3'b011);
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle RV32I controller: sequences FETCH/DECODE/EXEC/MEM/WB, drives all
// datapath strobes and selects, counts retired instructions and traps on faults.
module rv32i_multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic                 br_taken,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic [3:0]           alusel,
  output logic                 sel_a,
  output logic                 sel_b,
  output logic [2:0]           imm_type,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e                 state_reg;
  logic                   illegal_reg;
  logic [INSTRET_W-1:0]   instret_reg;
  logic [31:0]            wait_cnt_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr;
  logic       is_branch, is_load, is_store;
  logic [3:0] dec_alusel;
  logic       dec_bad_funct;
  logic       funct7_rsvd;
  logic       dec_illegal;
  logic       timeout_hit;
  logic       retire;
  logic       unused_instr_bits;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);

  // Register numbers are consumed by the datapath, not by the controller
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  rv32i_alu_decode u_alu_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (instr[30]),
    .alusel    (dec_alusel),
    .illegal   (dec_bad_funct)
  );

  // Every funct7 bit except bit 5 must be zero wherever funct7 is meaningful
  assign funct7_rsvd = |{instr[31], instr[29:25]};
  assign dec_illegal = dec_bad_funct |
                       (funct7_rsvd & (is_op | (is_opimm & (funct3 == 3'b001 || funct3 == 3'b101))));

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt_reg == TO_LAST);

  always_comb begin
    imm_type = IMM_I;
    if (is_store)                imm_type = IMM_S;
    else if (is_branch)          imm_type = IMM_B;
    else if (is_lui || is_auipc) imm_type = IMM_U;
    else if (is_jal)             imm_type = IMM_J;
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    alusel   = ALU_ADD;
    sel_a    = 1'b0;
    sel_b    = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    // Requests are forced low while reset is held, independent of the clock
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXEC: begin
          alusel = dec_alusel;
          sel_a  = is_auipc | is_jal | is_branch;
          sel_b  = ~is_op;
          if (is_branch) begin
            pc_we  = 1'b1;
            pc_sel = br_taken;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ack && is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          if (is_load)                wb_sel = WB_MEM;
          else if (is_jal || is_jalr) wb_sel = WB_PC4;
          pc_we  = 1'b1;
          pc_sel = is_jal | is_jalr;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      illegal_reg  <= 1'b0;
      instret_reg  <= '0;
      wait_cnt_reg <= '0;
    end else begin
      if (retire)
        instret_reg <= instret_reg + INSTRET_W'(1);
      case (state_reg)
        S_FETCH: begin
          if (imem_ack) begin
            state_reg    <= S_DECODE;
            wait_cnt_reg <= '0;
          end else if (timeout_hit) begin
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_branch)                 state_reg <= S_FETCH;
          else if (is_load || is_store)  state_reg <= S_MEM;
          else                           state_reg <= S_WB;
        end
        S_MEM: begin
          if (dmem_ack) begin
            state_reg    <= is_load ? S_WB : S_FETCH;
            wait_cnt_reg <= '0;
          end else if (timeout_hit) begin
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        S_WB:    state_reg <= S_FETCH;
        S_TRAP:  state_reg <= S_TRAP;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign illegal = illegal_reg;
  assign instret = instret_reg;

endmodule
